// File: rtl/uart_tx_drain_if.sv
// Queue-to-transmitter pop handshake for a show-ahead queue.
//   q_empty   : queue has no element at its head
//   q_rd_data : head element, valid whenever q_empty=0
//   q_re      : pop request, the pop takes effect at the next rising edge
// master: the drain (consumer) side. slave: the queue side.
interface uart_tx_drain_if #(
  parameter int unsigned DATA_W = 8
);
  logic              q_empty;
  logic [DATA_W-1:0] q_rd_data;
  logic              q_re;

  modport master (input q_empty, input q_rd_data, output q_re);
  modport slave  (output q_empty, output q_rd_data, input q_re);
endinterface

// File: rtl/uart_tx_drain.sv
// UART transmitter that drains a show-ahead queue, one frame per element.
// Frame: one start bit (low), DATA_W data bits LSB first, STOP_BITS stop bits
// (high). Each bit lasts CLKS_PER_BIT cycles, and the transmitter spends at
// least one idle cycle between frames.
//   clk        : clock, all state on rising edge
//   reset      : asynchronous, active-low reset; aborts any frame in flight
//   en         : permits starting a new frame (never aborts one)
//   q          : queue pop handshake (master side)
//   tx         : serial line, idle high
//   busy       : high while a frame is in progress
//   frame_done : one-cycle pulse on the final stop-bit cycle
module uart_tx_drain #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  uart_tx_drain_if.master  q,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W  = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state, state_n;
  logic [BAUD_W-1:0]  baud_cnt, baud_cnt_n;
  logic [BIT_W-1:0]   bit_cnt, bit_cnt_n;
  logic [DATA_W-1:0]  shift, shift_n;
  logic               baud_last;

  assign baud_last = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));

  // State, counters and shift register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_cnt  <= bit_cnt_n;
      shift    <= shift_n;
    end
  end

  // Next state and line outputs. In STOP the bit counter counts stop bits.
  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    q.q_re     = 1'b0;
    tx         = 1'b1;
    busy       = 1'b1;
    frame_done = 1'b0;

    case (state)
      IDLE: begin
        busy = 1'b0;
        // reset term keeps the pop request off while reset is held low
        if (reset && en && !q.q_empty) begin
          q.q_re     = 1'b1;
          shift_n    = q.q_rd_data;
          baud_cnt_n = '0;
          bit_cnt_n  = '0;
          state_n    = START;
        end
      end

      START: begin
        tx = 1'b0;
        if (baud_last) begin
          baud_cnt_n = '0;
          bit_cnt_n  = '0;
          state_n    = DATA;
        end else begin
          baud_cnt_n = baud_cnt + BAUD_W'(1);
        end
      end

      DATA: begin
        tx = shift[0];
        if (baud_last) begin
          baud_cnt_n = '0;
          shift_n    = shift >> 1;
          if (bit_cnt == BIT_W'(DATA_W - 1)) begin
            bit_cnt_n = '0;
            state_n   = STOP;
          end else begin
            bit_cnt_n = bit_cnt + BIT_W'(1);
          end
        end else begin
          baud_cnt_n = baud_cnt + BAUD_W'(1);
        end
      end

      STOP: begin
        if (baud_last) begin
          baud_cnt_n = '0;
          if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
            frame_done = 1'b1;
            bit_cnt_n  = '0;
            state_n    = IDLE;
          end else begin
            bit_cnt_n = bit_cnt + BIT_W'(1);
          end
        end else begin
          baud_cnt_n = baud_cnt + BAUD_W'(1);
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Self-checking bench for uart_tx_drain: two instances (1 and 2 stop bits),
// each fed by a bench-side show-ahead queue, checked every cycle against a
// frame-timeline reference model plus directed tables and sequences.
module tb_uart_tx_drain;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic reset;
  logic en;
  logic tx0, busy0, fd0;
  logic tx1, busy1, fd1;

  uart_tx_drain_if #(.DATA_W(8)) if0 ();
  uart_tx_drain_if #(.DATA_W(8)) if1 ();

  uart_tx_drain #(.CLKS_PER_BIT(CPB), .DATA_W(8), .STOP_BITS(1)) dut0 (
    .clk(clk), .reset(reset), .en(en), .q(if0),
    .tx(tx0), .busy(busy0), .frame_done(fd0)
  );

  uart_tx_drain #(.CLKS_PER_BIT(CPB), .DATA_W(8), .STOP_BITS(2)) dut1 (
    .clk(clk), .reset(reset), .en(en), .q(if1),
    .tx(tx1), .busy(busy1), .frame_done(fd1)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] fifo0[$];
  logic [7:0] fifo1[$];
  int         pos0, pos1;   // 0 = idle, else 1-based cycle index within the frame
  logic [7:0] cur0, cur1;
  logic       pop0, pop1;
  logic       rst_req, en_req;

  typedef struct packed {
    int unsigned cyc;
    logic        tx;
    logic        busy;
    logic        fd;
    logic        q_re;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Expected outputs from the frame position: bit slot k = (p-1)/CPB.
  function automatic void model(input int p, input logic [7:0] b, input int sb,
                                input logic empty, output logic etx,
                                output logic eb, output logic efd, output logic eqr);
    int f;
    int k;
    f = (1 + 8 + sb) * CPB;
    if (p == 0) begin
      etx = 1'b1; eb = 1'b0; efd = 1'b0;
      eqr = reset && en && !empty;
    end else begin
      k   = (p - 1) / CPB;
      etx = (k == 0) ? 1'b0 : ((k <= 8) ? b[k-1] : 1'b1);
      eb  = 1'b1;
      efd = (p == f);
      eqr = 1'b0;
    end
  endfunction

  // One clock cycle: apply queue pops, advance model, drive inputs, compare.
  task automatic cycle();
    logic etx, eb, efd, eqr;
    @(posedge clk);
    #1;
    if (pop0) begin cur0 = fifo0.pop_front(); pos0 = 1; end
    else if (pos0 != 0) pos0 = (pos0 == 10 * CPB) ? 0 : pos0 + 1;
    if (pop1) begin cur1 = fifo1.pop_front(); pos1 = 1; end
    else if (pos1 != 0) pos1 = (pos1 == 11 * CPB) ? 0 : pos1 + 1;
    reset = rst_req;
    en    = en_req;
    if (!rst_req) begin pos0 = 0; pos1 = 0; end
    if0.q_empty   = (fifo0.size() == 0);
    if0.q_rd_data = (fifo0.size() != 0) ? fifo0[0] : 8'($urandom);
    if1.q_empty   = (fifo1.size() == 0);
    if1.q_rd_data = (fifo1.size() != 0) ? fifo1[0] : 8'($urandom);
    #1;
    model(pos0, cur0, 1, if0.q_empty, etx, eb, efd, eqr);
    chk("m0_tx", tx0, etx);   chk("m0_busy", busy0, eb);
    chk("m0_fd", fd0, efd);   chk("m0_q_re", if0.q_re, eqr);
    model(pos1, cur1, 2, if1.q_empty, etx, eb, efd, eqr);
    chk("m1_tx", tx1, etx);   chk("m1_busy", busy1, eb);
    chk("m1_fd", fd1, efd);   chk("m1_q_re", if1.q_re, eqr);
    pop0 = if0.q_re && !if0.q_empty;
    pop1 = if1.q_re && !if1.q_empty;
  endtask

  initial begin
    int cnt, first, second, viol, fd_t, qre1_2nd, qre_cnt, fd_cnt;

    tbl[0]  = '{0,  1'b1, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1,  1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{4,  1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{5,  1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{9,  1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{13, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{17, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{21, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{25, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{29, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{33, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{36, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{37, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{39, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{40, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[15] = '{41, 1'b1, 1'b0, 1'b0, 1'b0};

    reset = 1'b0; en = 1'b1; rst_req = 1'b0; en_req = 1'b1;
    if0.q_empty = 1'b1; if0.q_rd_data = 8'h00;
    if1.q_empty = 1'b1; if1.q_rd_data = 8'h00;
    pos0 = 0; pos1 = 0; cur0 = 8'h00; cur1 = 8'h00; pop0 = 1'b0; pop1 = 1'b0;

    // Reset held, then release with empty queues for 100 cycles
    repeat (5) cycle();
    rst_req = 1'b1;
    viol = 0;
    repeat (100) begin
      cycle();
      if (tx0 !== 1'b1 || busy0 !== 1'b0 || if0.q_re !== 1'b0) viol++;
    end
    chk("empty_idle_violations", viol, 0);

    // Single 0xA5 frame (table) and a 0x3C frame with two stop bits
    fifo0.push_back(8'hA5);
    fifo1.push_back(8'h3C);
    fifo1.push_back(8'h5A);
    fd_t = -1; qre1_2nd = -1;
    for (int t = 0; t < 50; t++) begin
      cycle();
      for (int i = 0; i < 16; i++) begin
        if (tbl[i].cyc == t) begin
          chk("tbl_tx", tx0, tbl[i].tx);
          chk("tbl_busy", busy0, tbl[i].busy);
          chk("tbl_fd", fd0, tbl[i].fd);
          chk("tbl_q_re", if0.q_re, tbl[i].q_re);
        end
      end
      if (fd1 && fd_t < 0) fd_t = t;
      if (if1.q_re && t > 0 && qre1_2nd < 0) qre1_2nd = t;
    end
    chk("stop2_frame_done_cycle", fd_t, 44);
    chk("stop2_next_q_re_cycle", qre1_2nd, 45);

    // Back-to-back 0x00, 0xFF
    fifo0.push_back(8'h00);
    fifo0.push_back(8'hFF);
    cnt = 0; first = 0; second = 0;
    for (int t = 0; t < 120; t++) begin
      cycle();
      if (if0.q_re) begin
        if (cnt == 0) first = t;
        else if (cnt == 1) second = t;
        cnt++;
      end
    end
    chk("b2b_q_re_count", cnt, 2);
    chk("b2b_q_re_spacing", second - first, 41);

    // en dropped mid-frame with a non-empty queue
    fifo0.push_back(8'h12);
    fifo0.push_back(8'h34);
    fifo0.push_back(8'h56);
    qre_cnt = 0; fd_cnt = 0;
    for (int t = 0; t <= 100; t++) begin
      cycle();
      if (t > 10 && if0.q_re) qre_cnt++;
      if (fd0) fd_cnt++;
      if (t == 10) en_req = 1'b0;
    end
    chk("en_low_q_re_count", qre_cnt, 0);
    chk("en_low_frame_done_count", fd_cnt, 1);
    chk("en_low_busy_end", busy0, 0);
    en_req = 1'b1;
    cycle();
    chk("en_return_q_re", if0.q_re, 1);

    // Reset pulse during data bit 3 of the 0x34 frame
    cnt = 0; first = -1; viol = 0;
    for (int t = 1; t < 80; t++) begin
      cycle();
      if (t >= 18 && t <= 20) begin
        if (tx0 !== 1'b1 || busy0 !== 1'b0 || if0.q_re !== 1'b0) viol++;
      end
      if (t >= 21 && t <= 23 && if0.q_re) begin
        if (first < 0) first = t;
        cnt++;
      end
      if (t == 17) rst_req = 1'b0;
      if (t == 20) rst_req = 1'b1;
    end
    chk("reset_low_violations", viol, 0);
    chk("post_reset_q_re_cycle", first, 21);
    chk("post_reset_q_re_count", cnt, 1);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst_req = ($urandom_range(0, 499) != 0);
      en_req  = ($urandom_range(0, 7) != 0);
      if (fifo0.size() < 3 && $urandom_range(0, 59) == 0) fifo0.push_back(8'($urandom));
      if (fifo1.size() < 3 && $urandom_range(0, 59) == 0) fifo1.push_back(8'($urandom));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
